// File: rtl/lutram_stream_fifo.sv
// Purpose: show-ahead valid/ready FIFO, LUTRAM-mapped storage feeding an output register.
// Latency: first word visible 2 edges after it is pushed into an empty FIFO; 1 word/cycle sustained.
// Backpressure: in_ready drops only when the RAM is full (DEPTH words); it never looks at out_ready.
//
// Ports:
//   clk, rst              single rising-edge clock, synchronous active-high reset
//   in_data/valid/ready   producer side handshake
//   out_data/valid/ready  consumer side handshake, out_data is the head word (show-ahead)
//   count                 words held in RAM plus output register, 0..DEPTH+1
//   almost_full           registered, only when LUTRAM_FIFO_AFULL_EN is defined
//
// Optional feature macro: LUTRAM_FIFO_AFULL_EN (adds AFULL_THRESH and almost_full).

module lutram_stream_fifo #(
    parameter int D_WIDTH = 8,
    parameter int A_WIDTH = 5
`ifdef LUTRAM_FIFO_AFULL_EN
    ,
    parameter int AFULL_THRESH = 2**A_WIDTH - 4
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [D_WIDTH-1:0] in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [D_WIDTH-1:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [A_WIDTH:0]   count
`ifdef LUTRAM_FIFO_AFULL_EN
    ,
    output logic               almost_full
`endif
);

    localparam int DEPTH = 2**A_WIDTH;
    localparam logic [A_WIDTH:0] FULL_CNT = (A_WIDTH+1)'(DEPTH);

    // Storage: no reset, one write port, one registered read port.
    logic [D_WIDTH-1:0] ram_q [DEPTH-1:0];

    logic [A_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [A_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [A_WIDTH:0]   ram_cnt_q, ram_cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [D_WIDTH-1:0] out_data_q;

    logic push;
    logic load;
    logic pop;

    always_comb begin
        in_ready    = (ram_cnt_q != FULL_CNT);
        push        = in_valid && in_ready;
        // ram_cnt excludes the word being written this edge, so a load never
        // reads the address written on the same edge.
        load        = (ram_cnt_q != '0) && (!out_valid_q || out_ready);
        pop         = out_valid_q && out_ready;

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        out_valid_d = out_valid_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + A_WIDTH'(1);
        end
        if (load) begin
            rd_ptr_d    = rd_ptr_q + A_WIDTH'(1);
            out_valid_d = 1'b1;
        end else if (pop) begin
            out_valid_d = 1'b0;
        end

        ram_cnt_d = ram_cnt_q + (A_WIDTH+1)'(push) - (A_WIDTH+1)'(load);
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            ram_q[wr_ptr_q] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ram_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ram_cnt_q   <= ram_cnt_d;
            out_valid_q <= out_valid_d;
            // Registered read; out_data holds when no load, so it is stable
            // while the consumer stalls.
            if (load) begin
                out_data_q <= ram_q[rd_ptr_q];
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign count     = ram_cnt_q + (A_WIDTH+1)'(out_valid_q);

`ifdef LUTRAM_FIFO_AFULL_EN
    logic [A_WIDTH:0] count_d;
    logic             almost_full_q;

    assign count_d = ram_cnt_d + (A_WIDTH+1)'(out_valid_d);

    // Registered from next-state count so it moves on the same edge as count.
    always_ff @(posedge clk) begin
        if (rst) begin
            almost_full_q <= 1'b0;
        end else begin
            almost_full_q <= (int'(count_d) >= AFULL_THRESH);
        end
    end

    assign almost_full = almost_full_q;
`endif

endmodule

// File: tb/tb_lutram_stream_fifo.sv
// Purpose: self-checking bench for lutram_stream_fifo (default parameters, optional feature off).
// Latency: queue-level reference model compared every cycle, plus directed literal checks.
// Backpressure: exercises full, drain, streaming wrap, toggled out_ready and mid-stream reset.

module tb_lutram_stream_fifo;

    localparam int DW    = 8;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [AW:0]   count;

    lutram_stream_fifo #(.D_WIDTH(DW), .A_WIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Reference model: every word held, oldest first; m_vis says the head is
    // presented on out_data. Words in RAM = m_q.size() - m_vis.
    int m_q[$];
    bit m_vis = 1'b0;

    always @(posedge clk) begin
        int  in_ram;
        bit  m_push, m_pop, m_load;
        if (rst) begin
            m_q.delete();
            m_vis = 1'b0;
        end else begin
            in_ram = m_q.size() - int'(m_vis);
            m_push = in_valid && (in_ram != DEPTH);
            m_pop  = m_vis && out_ready;
            m_load = (in_ram != 0) && (!m_vis || out_ready);
            if (m_pop) void'(m_q.pop_front());
            if (m_load)     m_vis = 1'b1;
            else if (m_pop) m_vis = 1'b0;
            if (m_push) m_q.push_back(int'(in_data));
        end
    end

    // Per-cycle comparison against the model, plus a stall-stability check.
    bit            cmp_en = 1'b0;
    bit            was_stalled = 1'b0;
    logic [DW-1:0] stalled_dat;

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_count", int'(count), m_q.size());
            chk("model_out_valid", int'(out_valid), int'(m_vis));
            chk("model_in_ready", int'(in_ready),
                int'((m_q.size() - int'(m_vis)) != DEPTH));
            if (m_vis && m_q.size() > 0) chk("model_out_data", int'(out_data), m_q[0]);
            if (was_stalled && out_valid) chk("stall_stable", int'(out_data), int'(stalled_dat));
        end
        was_stalled = out_valid && !out_ready;
        stalled_dat = out_data;
    end

    // Advance one edge; inputs change 2 time units after the edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    int got[$];
    int acc;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        cmp_en = 1'b1;

        // Reset state.
        chk("rst_count", int'(count), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_data", int'(out_data), 0);

        // Single word, 2-edge latency.
        in_valid = 1'b1; in_data = 8'hA5;
        cyc();
        in_valid = 1'b0;
        chk("single_not_yet_visible", int'(out_valid), 0);
        chk("single_count_e1", int'(count), 1);
        cyc();
        chk("single_out_valid", int'(out_valid), 1);
        chk("single_out_data", int'(out_data), 8'hA5);
        chk("single_count", int'(count), 1);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk("single_pop_count", int'(count), 0);
        chk("single_pop_valid", int'(out_valid), 0);

        // Fill with out_ready low: 32 in RAM + 1 in output register.
        acc = 0;
        for (int i = 0; i <= 40; i++) begin
            in_valid = 1'b1; in_data = DW'(i);
            if (in_ready) acc++;
            cyc();
        end
        in_valid = 1'b0;
        chk("fill_accepted", acc, 33);
        chk("fill_count", int'(count), 33);
        chk("fill_in_ready", int'(in_ready), 0);
        chk("fill_out_data", int'(out_data), 0);

        // Drain.
        got.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) got.push_back(int'(out_data));
            cyc();
            if (i == 0) chk("drain_in_ready_back", int'(in_ready), 1);
        end
        out_ready = 1'b0;
        chk("drain_len", got.size(), 33);
        for (int i = 0; i < got.size() && i < 33; i++) chk("drain_seq", got[i], i);
        chk("drain_count", int'(count), 0);

        // Streaming across pointer wrap.
        got.delete();
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_data = DW'(8'h40 + i);
            if (out_valid) got.push_back(int'(out_data));
            if (i == 50) chk("stream_count_2", int'(count), 2);
            cyc();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid) got.push_back(int'(out_data));
            cyc();
        end
        out_ready = 1'b0;
        chk("stream_len", got.size(), 100);
        for (int i = 0; i < got.size() && i < 100; i++) chk("stream_seq", got[i], (8'h40 + i) & 8'hFF);

        // Backpressure with toggling out_ready.
        begin
            int idx = 0;
            int k = 0;
            got.delete();
            while ((idx < 16 || got.size() < 16) && k < 200) begin
                in_valid  = (idx < 16);
                in_data   = DW'(8'h10 + idx);
                out_ready = ~k[0];
                if (out_valid && out_ready) got.push_back(int'(out_data));
                if (in_valid && in_ready) idx++;
                cyc();
                k++;
            end
            in_valid = 1'b0; out_ready = 1'b0;
            chk("bp_done_in_budget", int'(k < 200), 1);
            chk("bp_len", got.size(), 16);
            for (int i = 0; i < got.size() && i < 16; i++) chk("bp_seq", got[i], 8'h10 + i);
        end

        // Reset mid-stream with 7 words held.
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_data = DW'(8'h70 + i);
            cyc();
        end
        in_valid = 1'b0;
        chk("midrst_pre_count", int'(count), 7);
        rst = 1'b1; in_valid = 1'b1; in_data = 8'hEE; out_ready = 1'b1;
        cyc();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("midrst_count", int'(count), 0);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        in_valid = 1'b1; in_data = 8'h3C;
        cyc();
        in_valid = 1'b0;
        cyc();
        chk("midrst_first_valid", int'(out_valid), 1);
        chk("midrst_first_data", int'(out_data), 8'h3C);
        out_ready = 1'b1;
        cyc(); cyc();
        out_ready = 1'b0;
        chk("end_count", int'(count), 0);

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
